// File: rtl/pll40_pkg.sv
// Shared constants, types and helpers for the pll40_core_model PLL40 behavioural model.
package pll40_pkg;

  localparam int DIVQ_MIN         = 1;
  localparam int DIVQ_MAX         = 6;
  localparam int DIVR_W           = 4;
  localparam int DIVF_W           = 7;
  localparam int FILTER_RANGE_W   = 3;
  localparam int FILTER_RANGE_MAX = (1 << FILTER_RANGE_W) - 1;

  localparam string FEEDBACK_SIMPLE = "SIMPLE";
  localparam string PLLOUT_GENCLK   = "GENCLK";

  typedef enum logic [1:0] {
    NCO_OFF,
    NCO_BYPASS,
    NCO_RUN,
    NCO_SAT
  } nco_mode_e;

  // Room for T = P * 2^DIVR_W * 2^DIVQ_MAX plus one increment.
  function automatic int acc_width(input int period_w);
    return period_w + 11;
  endfunction

endpackage

// File: rtl/pll40_core_model_if.sv
// Reference/control/output bundle of the PLL40 core model.
// The lock signal exists only when PLL40_LOCK_OUT_EN is defined.
interface pll40_core_model_if;

  logic reference_clk;
  logic resetb;
  logic bypass;
  logic pllout_core;
`ifdef PLL40_LOCK_OUT_EN
  logic lock;

  modport master (output reference_clk, resetb, bypass, input pllout_core, lock);
  modport slave  (input reference_clk, resetb, bypass, output pllout_core, lock);
`else
  modport master (output reference_clk, resetb, bypass, input pllout_core);
  modport slave  (input reference_clk, resetb, bypass, output pllout_core);
`endif

endinterface

// File: rtl/pll40_period_meter.sv
// Synchronizes the reference clock and measures its period in clk cycles,
// flagging each measurement as valid or saturated (bad).
module pll40_period_meter
  import pll40_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_in,
  output logic                ref_sync,
  output logic                meas_valid,
  output logic                meas_bad,
  output logic [PERIOD_W-1:0] p_new
);

  logic                sync1;
  logic                sync2;
  logic                sync3;
  logic                seen_edge;
  logic                ref_rise;
  logic                count_sat;
  logic [PERIOD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      seen_edge <= 1'b0;
      count     <= '0;
    end else begin
      sync1 <= ref_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (ref_rise) begin
        count     <= '0;
        seen_edge <= 1'b1;
      end else if (!count_sat) begin
        count <= count + PERIOD_W'(1);
      end
    end
  end

  // The first edge after reset only starts the counter; it has no prior edge to measure against.
  assign ref_rise   = sync2 & ~sync3;
  assign count_sat  = (count == '1);
  assign ref_sync   = sync2;
  assign meas_valid = ref_rise & seen_edge & ~count_sat;
  assign meas_bad   = ref_rise & seen_edge & count_sat;
  assign p_new      = count + PERIOD_W'(1);

endmodule

// File: rtl/pll40_core_model.sv
// pll40_core_model: cycle-based PLL40 core (SIMPLE feedback, GENCLK output) built from a period meter and an NCO.
// Define PLL40_LOCK_OUT_EN to expose the lock indicator on the interface.
module pll40_core_model
  import pll40_pkg::*;
#(
  parameter string              FEEDBACK_PATH = "SIMPLE",
  parameter string              PLLOUT_SELECT = "GENCLK",
  parameter logic [DIVR_W-1:0]  DIVR          = 4'd0,
  parameter logic [DIVF_W-1:0]  DIVF          = 7'd49,
  parameter logic [2:0]         DIVQ          = 3'd3,
  parameter int                 FILTER_RANGE  = 1,
  parameter int                 PERIOD_W      = 16,
  parameter int                 LOCK_COUNT    = 4
) (
  input logic               clk,
  input logic               rst,
  pll40_core_model_if.slave pll
);

  localparam int                 ACC_W      = acc_width(PERIOD_W);
  localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam int                 Q_EFF      = (DIVQ == 3'd0) ? DIVQ_MIN : int'(DIVQ);
  localparam logic [ACC_W-1:0]   INC        = ACC_W'(2 * (int'(DIVF) + 1));
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

  if (FEEDBACK_PATH != FEEDBACK_SIMPLE) begin : g_bad_feedback
    $error("pll40_core_model: only SIMPLE feedback is supported");
  end
  if (PLLOUT_SELECT != PLLOUT_GENCLK) begin : g_bad_select
    $error("pll40_core_model: only GENCLK output is supported");
  end
  if (int'(DIVQ) > DIVQ_MAX) begin : g_bad_divq
    $error("pll40_core_model: DIVQ out of range");
  end
  if (FILTER_RANGE < 0 || FILTER_RANGE > FILTER_RANGE_MAX) begin : g_bad_filter
    $error("pll40_core_model: FILTER_RANGE out of range");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock_count
    $error("pll40_core_model: LOCK_COUNT must be at least 1");
  end

  logic                pll_rst;
  logic                ref_sync;
  logic                meas_valid;
  logic                meas_bad;
  logic [PERIOD_W-1:0] p_new;
  logic [PERIOD_W-1:0] p_lock;
  logic [PERIOD_W-1:0] p_diff;
  logic                have_prev;
  logic                locked;
  logic [MATCH_W-1:0]  match_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    thresh;
  logic                pll_out;
  nco_mode_e           mode;

  assign pll_rst = rst | ~pll.resetb;

  pll40_period_meter #(
    .PERIOD_W (PERIOD_W)
  ) u_period_meter (
    .clk        (clk),
    .rst        (pll_rst),
    .ref_in     (pll.reference_clk),
    .ref_sync   (ref_sync),
    .meas_valid (meas_valid),
    .meas_bad   (meas_bad),
    .p_new      (p_new)
  );

  assign p_diff = (p_new >= p_lock) ? (p_new - p_lock) : (p_lock - p_new);
  assign locked = (match_cnt == MATCH_FULL);

  // p_lock doubles as the previous measurement; a measurement with no predecessor counts as the first match.
  always_ff @(posedge clk) begin
    if (pll_rst) begin
      match_cnt <= '0;
      have_prev <= 1'b0;
      p_lock    <= '0;
    end else if (meas_bad) begin
      match_cnt <= '0;
      have_prev <= 1'b0;
    end else if (meas_valid) begin
      have_prev <= 1'b1;
      p_lock    <= p_new;
      if (!have_prev || p_diff <= PERIOD_W'(1)) begin
        if (!locked) begin
          match_cnt <= match_cnt + MATCH_W'(1);
        end
      end else begin
        match_cnt <= '0;
      end
    end
  end

  assign thresh  = (ACC_W'(p_lock) * ACC_W'(int'(DIVR) + 1)) << Q_EFF;
  assign acc_sum = acc + INC;

  always_comb begin
    mode = NCO_OFF;
    if (pll.bypass) begin
      mode = NCO_BYPASS;
    end else if (locked) begin
      mode = (INC >= thresh) ? NCO_SAT : NCO_RUN;
    end
  end

  // Each toggle spends T/INC clk on average, giving the PLL40 output frequency.
  always_ff @(posedge clk) begin
    if (pll_rst) begin
      acc     <= '0;
      pll_out <= 1'b0;
    end else begin
      case (mode)
        NCO_BYPASS: begin
          acc     <= '0;
          pll_out <= ref_sync;
        end
        NCO_SAT: begin
          acc     <= '0;
          pll_out <= ~pll_out;
        end
        NCO_RUN: begin
          if (acc_sum >= thresh) begin
            acc     <= acc_sum - thresh;
            pll_out <= ~pll_out;
          end else begin
            acc <= acc_sum;
          end
        end
        default: begin
          acc     <= '0;
          pll_out <= 1'b0;
        end
      endcase
    end
  end

  assign pll.pllout_core = pll_out;
`ifdef PLL40_LOCK_OUT_EN
  assign pll.lock = locked;
`endif

endmodule

// File: tb/tb_pll40_core_model.sv
// Scoreboard bench for pll40_core_model: three configurations share one randomized reference.
// Lock is compared only when PLL40_LOCK_OUT_EN is defined.
module tb_pll40_core_model;

  localparam int NI         = 3;
  localparam int LOCK_N     = 4;
  localparam int PERIOD_MAX = 65535;
  localparam int MUL_DIVF   = 3;
  localparam int MUL_DIVQ   = 1;
  localparam int DEF_DIVF   = 49;
  localparam int DEF_DIVQ   = 3;
  localparam int SAT_DIVF   = 127;
  localparam int SAT_DIVQ   = 1;

  typedef struct packed {
    logic [NI-1:0] out;
    logic          lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resetb = 1'b1;
  logic bypass = 1'b0;
  logic ref_clk = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];

  int cfg_divf[NI] = '{MUL_DIVF, DEF_DIVF, SAT_DIVF};
  int cfg_divq[NI] = '{MUL_DIVQ, DEF_DIVQ, SAT_DIVQ};
  string cfg_name[NI] = '{"mul", "def", "sat"};

  int hist[3] = '{0, 0, 0};
  int last_rise = -1;
  int cyc = 0;
  int match_n = 0;
  bit have_prev = 1'b0;
  int p_last = 0;
  int acc_m[NI] = '{0, 0, 0};
  bit out_m[NI] = '{1'b0, 1'b0, 1'b0};

  int toggles[NI] = '{0, 0, 0};
  int snap[NI];

  always #5 clk = ~clk;

  pll40_core_model_if if_mul();
  pll40_core_model_if if_def();
  pll40_core_model_if if_sat();

  assign if_mul.reference_clk = ref_clk;
  assign if_mul.resetb        = resetb;
  assign if_mul.bypass        = bypass;
  assign if_def.reference_clk = ref_clk;
  assign if_def.resetb        = resetb;
  assign if_def.bypass        = bypass;
  assign if_sat.reference_clk = ref_clk;
  assign if_sat.resetb        = resetb;
  assign if_sat.bypass        = bypass;

  pll40_core_model #(.DIVR(4'd0), .DIVF(7'(MUL_DIVF)), .DIVQ(3'(MUL_DIVQ)))
    u_mul (.clk(clk), .rst(rst), .pll(if_mul));
  pll40_core_model u_def (.clk(clk), .rst(rst), .pll(if_def));
  pll40_core_model #(.DIVR(4'd0), .DIVF(7'(SAT_DIVF)), .DIVQ(3'(SAT_DIVQ)))
    u_sat (.clk(clk), .rst(rst), .pll(if_sat));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One reference cycle per iteration: rising at the first clk, random duty cycle.
  task automatic applyStimulus(input int period, input int n);
    for (int c = 0; c < n; c++) begin
      int hi;
      hi = $urandom_range(period - 1, 1);
      for (int k = 0; k < period; k++) begin
        @(negedge clk);
        ref_clk = (k < hi);
      end
    end
  endtask

  task automatic pulseReset(input bit use_resetb);
    @(negedge clk);
    if (use_resetb) resetb = 1'b0;
    else rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resetb = 1'b1;
  endtask

  // Reference model: edges timestamped in clk, periods are timestamp differences,
  // output frequency follows f_ref*(DIVF+1)/((DIVR+1)*2^DIVQ) via a threshold accumulator.
  initial begin : ref_model
    exp_t e;
    bit   synced, rise, lk;
    int   p, t, inc, scale;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst || !resetb) begin
        hist = '{0, 0, 0};
        last_rise = -1;
        match_n = 0;
        have_prev = 1'b0;
        p_last = 0;
        for (int i = 0; i < NI; i++) begin
          acc_m[i] = 0;
          out_m[i] = 1'b0;
        end
      end else begin
        synced = (hist[1] != 0);
        rise   = synced && (hist[2] == 0);
        lk     = (match_n == LOCK_N);
        for (int i = 0; i < NI; i++) begin
          inc   = 2 * (cfg_divf[i] + 1);
          scale = 1 << cfg_divq[i];
          if (bypass) begin
            acc_m[i] = 0;
            out_m[i] = synced;
          end else if (!lk) begin
            acc_m[i] = 0;
            out_m[i] = 1'b0;
          end else begin
            t = p_last * scale;
            if (inc >= t) begin
              acc_m[i] = 0;
              out_m[i] = !out_m[i];
            end else if (acc_m[i] + inc >= t) begin
              acc_m[i] = acc_m[i] + inc - t;
              out_m[i] = !out_m[i];
            end else begin
              acc_m[i] = acc_m[i] + inc;
            end
          end
        end
        if (rise) begin
          if (last_rise >= 0) begin
            p = cyc - last_rise;
            if (p - 1 >= PERIOD_MAX) begin
              match_n = 0;
              have_prev = 1'b0;
            end else begin
              if (!have_prev || (p - p_last <= 1 && p_last - p <= 1)) begin
                if (match_n < LOCK_N) match_n++;
              end else begin
                match_n = 0;
              end
              p_last = p;
              have_prev = 1'b1;
            end
          end
          last_rise = cyc;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = ref_clk ? 1 : 0;
      end
      for (int i = 0; i < NI; i++) e.out[i] = out_m[i];
      e.lk = (match_n == LOCK_N);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [NI-1:0] act;
    logic [NI-1:0] prev;
    bit          first;
    first = 1'b1;
    forever begin
      @(negedge clk);
      act = {if_sat.pllout_core, if_def.pllout_core, if_mul.pllout_core};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          checkOutput({"pllout_", cfg_name[i]}, 32'(act[i]), 32'(e.out[i]));
        end
`ifdef PLL40_LOCK_OUT_EN
        checkOutput("lock_mul", 32'(if_mul.lock), 32'(e.lk));
        checkOutput("lock_def", 32'(if_def.lock), 32'(e.lk));
        checkOutput("lock_sat", 32'(if_sat.lock), 32'(e.lk));
`endif
      end
      if (!first) begin
        for (int i = 0; i < NI; i++) begin
          if (act[i] !== prev[i]) toggles[i]++;
        end
      end
      prev  = act;
      first = 1'b0;
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] multiply and saturation, ref period 16");
    applyStimulus(16, 10);
    @(posedge clk);
    snap = toggles;
    applyStimulus(16, 50);
    @(posedge clk);
    checkOutput("mul_toggles_p16", 32'(toggles[0] - snap[0]), 32'd200);
    checkOutput("sat_toggles_p16", 32'(toggles[2] - snap[2]), 32'd800);

    $display("[TB] jitter 16/17 then one 24 period");
    for (int j = 0; j < 20; j++) applyStimulus(16 + $urandom_range(1, 0), 1);
    applyStimulus(24, 1);
    applyStimulus(16, 8);

    $display("[TB] mid-run resets");
    applyStimulus(16, $urandom_range(12, 8));
    pulseReset(1'b0);
    applyStimulus(16, 8);
    pulseReset(1'b1);
    applyStimulus(16, 8);

    $display("[TB] bypass");
    pulseReset(1'b0);
    bypass = 1'b1;
    for (int j = 0; j < 10; j++) applyStimulus($urandom_range(12, 4), 1);
    bypass = 1'b0;
    applyStimulus(16, 8);

    $display("[TB] default ratio, ref period 400");
    pulseReset(1'b0);
    applyStimulus(400, 7);
    @(posedge clk);
    snap = toggles;
    applyStimulus(400, 2);
    @(posedge clk);
    checkOutput("def_toggles_p400", 32'(toggles[1] - snap[1]), 32'd25);
    checkOutput("mul_toggles_p400", 32'(toggles[0] - snap[0]), 32'd8);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
